// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared, externally settled ALU
// Optional feature macro: ALU_ARB_OPCHECK_EN (reject opcodes 1100..1111 without touching the ALU)

module alu_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_result,
  output logic [15:0] rsp_product,
  output logic        rsp_of,
  output logic        rsp_zero,
  output logic        rsp_slt,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic [15:0] alu_product,
  input  logic        alu_of,
  input  logic        alu_zero,
  input  logic        alu_slt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter value seen on the last settle cycle before capture
  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_result_q, rsp_result_d;
  logic [15:0] rsp_product_q, rsp_product_d;
  logic        rsp_of_q, rsp_of_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_slt_q, rsp_slt_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic        rsp_err_q, rsp_err_d;
`endif

  logic        gnt0, gnt1, hs, sel_id, bypass;
  logic [7:0]  sel_a, sel_b;
  logic [3:0]  sel_op;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last_q);
    gnt1       = req1_valid && (!req0_valid || !last_q);
    req0_ready = (state_q == IDLE) && !rst && gnt0;
    req1_ready = (state_q == IDLE) && !rst && gnt1;
    hs         = req0_ready || req1_ready;
    sel_id     = req1_ready;
    sel_a      = sel_id ? req1_a  : req0_a;
    sel_b      = sel_id ? req1_b  : req0_b;
    sel_op     = sel_id ? req1_op : req0_op;
`ifdef ALU_ARB_OPCHECK_EN
    bypass     = (sel_op[3:2] == 2'b11);
`else
    bypass     = 1'b0;
`endif
  end

  // Next-state and next-output computation for the IDLE/WAIT/RESP sequence
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_product_d = rsp_product_q;
    rsp_of_d      = rsp_of_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_slt_d     = rsp_slt_q;
`ifdef ALU_ARB_OPCHECK_EN
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          rsp_id_d = sel_id;
          last_d   = sel_id;
          if (bypass) begin
            // Rejected opcode: answer immediately, ALU drive left as it was
            rsp_result_d  = 8'h00;
            rsp_product_d = 16'h0000;
            rsp_of_d      = 1'b0;
            rsp_zero_d    = 1'b0;
            rsp_slt_d     = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err_d     = 1'b1;
`endif
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
          end else begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            cnt_d    = 4'd0;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rsp_result_d  = alu_result;
          rsp_product_d = alu_product;
          rsp_of_d      = alu_of;
          rsp_zero_d    = alu_zero;
          rsp_slt_d     = alu_slt;
`ifdef ALU_ARB_OPCHECK_EN
          rsp_err_d     = 1'b0;
`endif
          rsp_valid_d   = 1'b1;
          cnt_d         = 4'd0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      cnt_q         <= 4'd0;
      alu_a_q       <= 8'h00;
      alu_b_q       <= 8'h00;
      alu_op_q      <= 4'hF;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= 8'h00;
      rsp_product_q <= 16'h0000;
      rsp_of_q      <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_slt_q     <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_product_q <= rsp_product_d;
      rsp_of_q      <= rsp_of_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_slt_q     <= rsp_slt_d;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_product = rsp_product_q;
  assign rsp_of      = rsp_of_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_slt     = rsp_slt_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
Parameters and ports are listed one per line.

REQ-001 Parameter ALU_WAIT, default 1, sets the number of settle cycles between driving the ALU operands and capturing its outputs; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid, req1_valid  in  1  requester n presents a command.
REQ-005 req0_ready, req1_ready  out  1  command n accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  8  operands.
REQ-007 req0_op, req1_op  in  4  ALU opcode; encoding 0000..1011 is the shared ALU's, 1100..1111 means "set zero".
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  response consumer accepts.
REQ-010 rsp_id  out  1  index of the requester owning the response.
REQ-011 rsp_result  out  8  captured ALU result.
REQ-012 rsp_product  out  16  captured ALU product.
REQ-013 rsp_of, rsp_zero, rsp_slt  out  1  captured ALU flags.
REQ-014 rsp_err  out  1  illegal-opcode indication.
REQ-015 alu_a, alu_b  out  8  and alu_op  out  4: registered drive to the shared ALU.
REQ-016 alu_result  in  8, alu_product  in  16, alu_of / alu_zero / alu_slt  in  1: ALU outputs.

Function
REQ-017 The block SHALL use FSM states IDLE, WAIT and RESP.
REQ-018 In IDLE with at least one valid, the block SHALL grant round-robin: the requester not granted last wins a tie, and a single valid requester wins outright.
REQ-019 reqN_ready SHALL be high only in IDLE for the granted requester, and is combinational from the valids.
REQ-020 On the IDLE handshake (cycle T), the block SHALL register a, b and op into alu_a/alu_b/alu_op, record rsp_id, update the last-grant pointer and enter WAIT.
REQ-021 WAIT SHALL last exactly ALU_WAIT cycles, counted by an internal counter. At the final WAIT edge the block SHALL capture alu_result, alu_product, alu_of, alu_zero and alu_slt into the rsp_* registers and enter RESP.
REQ-022 rsp_valid SHALL first be high in cycle T+1+ALU_WAIT.
REQ-023 alu_a, alu_b and alu_op SHALL hold stable from T+1 until the next handshake.
REQ-024 In RESP, all rsp_* outputs SHALL hold stable while rsp_ready is low. Both req ready outputs SHALL stay low, and no grant occurs.
REQ-025 When rsp_valid and rsp_ready are both high, the block SHALL return to IDLE the next cycle.
REQ-026 Minimum issue spacing SHALL be ALU_WAIT+2 cycles.
REQ-027 A requester SHALL keep a, b and op stable only until its ready handshake; later changes have no effect.
REQ-028 rsp_err SHALL be 0 for every response produced through WAIT.

Reset
REQ-029 While rst is high at a clock edge: state is IDLE; req0_ready, req1_ready and rsp_valid are 0; all rsp_* registers are 0; alu_a and alu_b are 0; alu_op is 1111; the WAIT counter is 0; the last-grant pointer is 1, so req0 wins the first tie.
REQ-030 rst asserted in WAIT or RESP SHALL abandon the operation without producing a response.

Configuration
REQ-031 Macro ALU_ARB_OPCHECK_EN, when defined: a handshake with op 1100..1111 SHALL bypass WAIT and leave alu_* unchanged. The block enters RESP in cycle T+1 with rsp_err=1, rsp_result=0, rsp_product=0, all flags 0 and the correct rsp_id.
REQ-032 When ALU_ARB_OPCHECK_EN is undefined, every opcode SHALL be forwarded through WAIT and rsp_err SHALL be tied to 0.

Verification
REQ-033 ALU_WAIT=1, req0 a=0x05 b=0x03 op=1001, rsp_ready=1 -> handshake at T; rsp_valid at T+2 with rsp_result=0x08, rsp_id=0, rsp_of=0, rsp_zero=0.
REQ-034 req0 and req1 valid continuously with four ops each -> responses in rsp_id order 0,1,0,1,... with no starvation.
REQ-035 req1 a=0xFD b=0x04 op=1011 -> rsp_product=0xFFF4, rsp_result=0x00, rsp_id=1.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_* stable; req0_ready and req1_ready stay 0; a new operation is granted only after the accepting cycle.
REQ-037 op=1100 from req0 -> with ALU_ARB_OPCHECK_EN: rsp_valid at T+1, rsp_err=1, alu_op unchanged. Without the macro: response at T+1+ALU_WAIT with rsp_err=0 and rsp_result=0x00.
REQ-038 rst pulsed during WAIT (ALU_WAIT=3) -> the next cycle shows IDLE with rsp_valid=0 and alu_op=1111; a pending req0 is granted afterwards.
